logic_unit_scheduler: RTL

- Shares one combinational Logic unit (AND/OR/XOR/NOTA/NOTB/CPR) between NUM_REQ requesters: round-robin arbitration, operand capture, result/flag registering and return to the granted requester.
- Sits between the CPU control units and the Logic unit instance inside the ALU.
- Uses DATA_WIDTH and enum_alu_opcode_t from CPU_package.

---
 rtl/logic_unit_scheduler.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/logic_unit_scheduler.sv
// ---------------------------------------------------------------------------
// logic_unit_scheduler
//
// Shares one combinational Logic unit (AND/OR/XOR/NOTA/NOTB/CPR) between
// NUM_REQ requesters. It arbitrates round-robin, captures the operands and
// opcode, registers the result and flags, and returns them to the granted
// requester. Each transaction passes through IDLE -> EXEC -> RESP -> IDLE.
//
// CPU_package supplies DATA_WIDTH and enum_alu_opcode_t. It is declared here
// so that this file is self-contained.
//
// Optional feature macro: LOGIC_SCHED_PRIO0_EN
//   defined   : requester 0 has fixed top priority and does not move rr_ptr
//   undefined : pure round-robin across all requesters
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   req_valid  in   [NUM_REQ]             request valid per requester
//   req_ready  out  [NUM_REQ]             request accept, at most one bit high
//   req_a      in   [NUM_REQ][DATA_WIDTH] operand A per requester
//   req_b      in   [NUM_REQ][DATA_WIDTH] operand B per requester
//   req_op     in   [NUM_REQ] opcode      opcode per requester
//   resp_valid out  [NUM_REQ]             response valid, one-hot to the grant
//   resp_ready in   [NUM_REQ]             response accept per requester
//   resp_data  out  [DATA_WIDTH]          shared result bus
//   resp_flag  out  [3]                   {greater,equal,lower}, CPR only
//   resp_err   out  1                     opcode is not a logic operation
//   busy       out  1                     high whenever state != IDLE
// ---------------------------------------------------------------------------

package CPU_package;
  localparam int DATA_WIDTH = 8;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_NOTA = 4'd5,
    ALU_NOTB = 4'd6,
    ALU_CPR  = 4'd7,
    ALU_SHL  = 4'd8,
    ALU_SHR  = 4'd9
  } enum_alu_opcode_t;
endpackage

module logic_unit_scheduler #(
  parameter int NUM_REQ    = 2,
  parameter int DATA_WIDTH = CPU_package::DATA_WIDTH
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic [NUM_REQ-1:0]                     req_valid,
  output logic [NUM_REQ-1:0]                     req_ready,
  input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]     req_a,
  input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]     req_b,
  input  CPU_package::enum_alu_opcode_t [NUM_REQ-1:0] req_op,
  output logic [NUM_REQ-1:0]                     resp_valid,
  input  logic [NUM_REQ-1:0]                     resp_ready,
  output logic [DATA_WIDTH-1:0]                  resp_data,
  output logic [2:0]                             resp_flag,
  output logic                                   resp_err,
  output logic                                   busy
);
  import CPU_package::*;

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

`ifdef LOGIC_SCHED_PRIO0_EN
  localparam bit PRIO0 = 1'b1;
`else
  localparam bit PRIO0 = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t                 state;
  logic [PTR_W-1:0]       rr_ptr;
  logic [PTR_W-1:0]       grant;
  logic [DATA_WIDTH-1:0]  a_q;
  logic [DATA_WIDTH-1:0]  b_q;
  enum_alu_opcode_t       op_q;

  logic [PTR_W-1:0]       winner;
  logic [PTR_W-1:0]       rr_next;
  logic [PTR_W:0]         scan_sum;
  logic [PTR_W:0]         next_sum;
  logic                   found;
  logic                   prio_win;
  logic [NUM_REQ-1:0]     winner_onehot;
  logic [NUM_REQ-1:0]     grant_onehot;

  logic [DATA_WIDTH-1:0]  logic_out;
  logic [2:0]             logic_out_flag;
  logic                   is_logic;

  // Round-robin search starting at rr_ptr. rr_ptr and k are both below
  // NUM_REQ, so a single conditional subtract gives the modulo without a
  // divider. With the priority option, requester 0 wins outright. When
  // requester 0 is not requesting, the ordinary scan skips it naturally.
  always_comb begin
    found    = 1'b0;
    prio_win = 1'b0;
    winner   = '0;
    scan_sum = '0;
    if (PRIO0 && req_valid[0]) begin
      found    = 1'b1;
      prio_win = 1'b1;
    end
    for (int k = 0; k < NUM_REQ; k++) begin
      scan_sum = {1'b0, rr_ptr} + (PTR_W+1)'(k);
      if (scan_sum >= (PTR_W+1)'(NUM_REQ))
        scan_sum = scan_sum - (PTR_W+1)'(NUM_REQ);
      if (!found && req_valid[scan_sum[PTR_W-1:0]]) begin
        found  = 1'b1;
        winner = scan_sum[PTR_W-1:0];
      end
    end
  end

  always_comb begin
    next_sum = {1'b0, winner} + (PTR_W+1)'(1);
    rr_next  = next_sum[PTR_W-1:0];
    if (next_sum == (PTR_W+1)'(NUM_REQ))
      rr_next = '0;
  end

  assign winner_onehot = NUM_REQ'(1) << winner;
  assign grant_onehot  = NUM_REQ'(1) << grant;

  // req_ready is combinational in IDLE so the handshake completes in the
  // cycle the request is offered. It is gated by rst_n so that it also stays
  // low while reset is held.
  assign req_ready = (rst_n && state == IDLE && found) ? winner_onehot : '0;

  // The shared Logic unit is driven only from the captured registers.
  // Non-logic opcodes leave the data and flags at zero and raise is_logic low.
  // CPR compares the operands as unsigned values.
  always_comb begin
    logic_out      = '0;
    logic_out_flag = 3'b000;
    is_logic       = 1'b1;
    case (op_q)
      ALU_AND:  logic_out = a_q & b_q;
      ALU_OR:   logic_out = a_q | b_q;
      ALU_XOR:  logic_out = a_q ^ b_q;
      ALU_NOTA: logic_out = ~a_q;
      ALU_NOTB: logic_out = ~b_q;
      ALU_CPR: begin
        if (a_q > b_q)
          logic_out_flag = 3'b100;
        else if (a_q == b_q)
          logic_out_flag = 3'b010;
        else
          logic_out_flag = 3'b001;
      end
      default:  is_logic = 1'b0;
    endcase
  end

  // Scheduler FSM. All outputs except req_ready are registered here.
  // An asynchronous reset drops any in-flight transaction without producing
  // a response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      grant      <= '0;
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= enum_alu_opcode_t'(4'd0);
      resp_valid <= '0;
      resp_data  <= '0;
      resp_flag  <= 3'b000;
      resp_err   <= 1'b0;
      busy       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            a_q   <= req_a[winner];
            b_q   <= req_b[winner];
            op_q  <= req_op[winner];
            grant <= winner;
            if (!prio_win)
              rr_ptr <= rr_next;
            busy  <= 1'b1;
            state <= EXEC;
          end
        end
        EXEC: begin
          resp_data  <= logic_out;
          resp_flag  <= logic_out_flag;
          resp_err   <= ~is_logic;
          resp_valid <= grant_onehot;
          state      <= RESP;
        end
        RESP: begin
          if (resp_ready[grant]) begin
            resp_valid <= '0;
            busy       <= 1'b0;
            state      <= IDLE;
          end
        end
        default: begin
          resp_valid <= '0;
          busy       <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule
